// File: rtl/seg_display_pkg.sv
// Shared definitions for seg_display_ctrl: register select codes, CTRL layout
// and the active-low {g,f,e,d,c,b,a} hex glyph table.
package seg_display_pkg;

  typedef enum logic [2:0] {
    SEL_VALUE = 3'd0,
    SEL_BLANK = 3'd1,
    SEL_BLINK = 3'd2,
    SEL_CTRL  = 3'd3,
    SEL_DP    = 3'd4
  } wr_sel_e;

  localparam int CTRL_SHIFT_EN = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_LZS_EN   = 2;

  typedef struct packed {
    logic lzs_en;
    logic blink_en;
    logic shift_en;
  } ctrl_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_glyph.sv
// Combinational nibble to active-low seven-segment glyph; zero latency, no flow control.
module hex_glyph
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Register-mapped NUM_DIGITS seven-segment driver; `define SEG_DP_EN adds the dp output.
// Register or blink-phase change reaches seg one edge later; no backpressure, writes and keys always accepted.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [2:0]                wr_sel,
  input  logic [31:0]               wr_data,
  input  logic                      key_valid,
  input  logic [7:0]                key_data,
  output logic [4*NUM_DIGITS-1:0]   value_q,
`ifdef SEG_DP_EN
  output logic [NUM_DIGITS-1:0]     dp,
`endif
  output logic [7*NUM_DIGITS-1:0]   seg
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [VW-1:0]           value_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic [NUM_DIGITS-1:0]   blink_r;
  ctrl_t                   ctrl_r;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [7*NUM_DIGITS-1:0] seg_r;

  logic                    value_wr;
  logic                    shift_fire;
  logic [VW+7:0]           shift_cat;
  logic [VW-1:0]           shifted;
  logic [6:0]              glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    hi_zero;
  logic [7*NUM_DIGITS-1:0] seg_next;

  assign value_wr   = wr_en && (wr_sel == SEL_VALUE);
  assign shift_fire = key_valid && ctrl_r.shift_en && !value_wr;

  // Concatenate-then-truncate covers NUM_DIGITS=1 (low nibble only) and 2 without special cases.
  assign shift_cat = {value_r, key_data};
  assign shifted   = shift_cat[VW-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    hex_glyph u_glyph (
      .nibble (value_r[4*g +: 4]),
      .glyph  (glyph[g])
    );
  end

  always_comb begin
    hi_zero = 1'b1;
    lz      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (value_r[4*i +: 4] == 4'd0);
      lz[i]   = ctrl_r.lzs_en & (i > 0) & hi_zero;
    end
    blank_vec = blank_r | ({NUM_DIGITS{ctrl_r.blink_en & blink_phase}} & blink_r) | lz;
    seg_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_next[7*i +: 7] = blank_vec[i] ? SEG_BLANK : glyph[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      value_r <= '0;
      blank_r <= '0;
      blink_r <= '0;
      ctrl_r  <= '0;
    end else begin
      if (shift_fire) value_r <= shifted;
      if (wr_en) begin
        case (wr_sel_e'(wr_sel))
          SEL_VALUE: value_r <= wr_data[VW-1:0];
          SEL_BLANK: blank_r <= wr_data[NUM_DIGITS-1:0];
          SEL_BLINK: blink_r <= wr_data[NUM_DIGITS-1:0];
          SEL_CTRL: begin
            ctrl_r.shift_en <= wr_data[CTRL_SHIFT_EN];
            ctrl_r.blink_en <= wr_data[CTRL_BLINK_EN];
            ctrl_r.lzs_en   <= wr_data[CTRL_LZS_EN];
          end
          default: ;
        endcase
      end
    end
  end

  // Timer free-runs so enabling blink later stays in step with other blink users.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) seg_r <= '1;
    else         seg_r <= seg_next;
  end

  assign seg     = seg_r;
  assign value_q = value_r;

`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0] dp_r;
  logic [NUM_DIGITS-1:0] dp_out_r;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dp_r     <= '0;
      dp_out_r <= '1;
    end else begin
      if (wr_en && (wr_sel == SEL_DP)) dp_r <= wr_data[NUM_DIGITS-1:0];
      dp_out_r <= ~(dp_r & ~blank_vec);
    end
  end

  assign dp = dp_out_r;
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl (NUM_DIGITS=8, BLINK_DIV=4): reference model feeds a per-edge scoreboard.
module tb_seg_display_ctrl;

  localparam int N  = 8;
  localparam int BD = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001, GF = 7'b0001110, DARK = 7'b1111111;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = '0;
  logic [31:0] wr_data = '0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_data = '0;
  logic [31:0] value_q;
  logic [55:0] seg;
`ifdef SEG_DP_EN
  logic [7:0]  dp;
`endif

  seg_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .key_valid (key_valid),
    .key_data  (key_data),
    .value_q   (value_q),
`ifdef SEG_DP_EN
    .dp        (dp),
`endif
    .seg       (seg)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] value;
    logic [55:0] seg;
    logic [7:0]  dp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] m_value = '0;
  logic [7:0]  m_blank = '0, m_blink = '0, m_dp = '0;
  logic [2:0]  m_ctrl = '0;
  int          m_cnt = 0;
  logic        m_phase = 1'b0;

  function automatic logic [6:0] tb_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] model_blank();
    logic [7:0] b;
    logic hz;
    hz = 1'b1;
    b  = '0;
    for (int i = 7; i >= 0; i--) begin
      hz   = hz && (m_value[4*i +: 4] == 4'd0);
      b[i] = m_blank[i] || (m_ctrl[1] && m_phase && m_blink[i]) || (m_ctrl[2] && i > 0 && hz);
    end
    return b;
  endfunction

  // Computes what the DUT must show after the coming edge, queues it, then advances one cycle.
  task automatic step();
    exp_t e;
    logic [7:0] bl;
    logic shift_ok;
    if (!resetn) begin
      m_value = '0; m_blank = '0; m_blink = '0; m_dp = '0; m_ctrl = '0;
      m_cnt = 0; m_phase = 1'b0;
      e.seg = '1;
      e.dp  = '1;
    end else begin
      bl = model_blank();
      for (int i = 0; i < 8; i++) e.seg[7*i +: 7] = bl[i] ? DARK : tb_glyph(m_value[4*i +: 4]);
      e.dp = ~(m_dp & ~bl);
      shift_ok = key_valid && m_ctrl[0] && !(wr_en && wr_sel == 3'd0);
      if (shift_ok) m_value = {m_value[23:0], key_data};
      if (wr_en) begin
        case (wr_sel)
          3'd0: m_value = wr_data;
          3'd1: m_blank = wr_data[7:0];
          3'd2: m_blink = wr_data[7:0];
          3'd3: m_ctrl  = wr_data[2:0];
`ifdef SEG_DP_EN
          3'd4: m_dp    = wr_data[7:0];
`endif
          default: ;
        endcase
      end
      if (m_cnt == BD - 1) begin
        m_cnt = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    e.value = m_value;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (value_q !== mon_e.value) begin
        errors++;
        $display("FAIL sb_value: got %h want %h at %0t", value_q, mon_e.value, $time);
      end
      checks++;
      if (seg !== mon_e.seg) begin
        errors++;
        $display("FAIL sb_seg: got %h want %h at %0t", seg, mon_e.seg, $time);
      end
`ifdef SEG_DP_EN
      checks++;
      if (dp !== mon_e.dp) begin
        errors++;
        $display("FAIL sb_dp: got %b want %b at %0t", dp, mon_e.dp, $time);
      end
`endif
    end
  end

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;
  endtask

  task automatic key(input logic [7:0] k);
    key_valid = 1'b1; key_data = k;
    step();
    key_valid = 1'b0; key_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(2);
    checks++;
    if (seg !== '1) begin errors++; $display("FAIL reset_seg: got %h want all ones", seg); end
    resetn = 1'b1;
    step();
    checks++;
    if (seg !== {8{G0}}) begin errors++; $display("FAIL release_seg: got %h want %h", seg, {8{G0}}); end
    checks++;
    if (value_q !== 32'h0) begin errors++; $display("FAIL release_value: got %h want 0", value_q); end
  endtask

  task automatic test_value();
    wr(3'd0, 32'h1234ABCD);
    checks++;
    if (value_q !== 32'h1234ABCD) begin errors++; $display("FAIL value_write: got %h want 1234abcd", value_q); end
    step();
    checks++;
    if (seg !== {G1, G2, G3, G4, GA, GB, GC, GD})
      begin errors++; $display("FAIL value_glyphs: got %h want %h", seg, {G1, G2, G3, G4, GA, GB, GC, GD}); end
  endtask

  task automatic test_shift();
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h1);
    key(8'h5A);
    key(8'h3C);
    checks++;
    if (value_q !== 32'h00005A3C) begin errors++; $display("FAIL shift_two: got %h want 00005a3c", value_q); end
    key_valid = 1'b1; key_data = 8'h77;
    wr(3'd0, 32'h11111111);
    key_valid = 1'b0;
    checks++;
    if (value_q !== 32'h11111111) begin errors++; $display("FAIL shift_vs_write: got %h want 11111111", value_q); end
    key_valid = 1'b1; key_data = 8'h22;
    wr(3'd1, 32'h0);
    key_valid = 1'b0;
    checks++;
    if (value_q !== 32'h11111122) begin errors++; $display("FAIL shift_other_write: got %h want 11111122", value_q); end
    wr(3'd3, 32'h0);
    key(8'h99);
    checks++;
    if (value_q !== 32'h11111122) begin errors++; $display("FAIL shift_disabled: got %h want 11111122", value_q); end
  endtask

  task automatic test_lzs();
    wr(3'd0, 32'h00000420);
    wr(3'd3, 32'h4);
    step();
    checks++;
    if (seg !== {DARK, DARK, DARK, DARK, DARK, G4, G2, G0})
      begin errors++; $display("FAIL lzs_420: got %h want %h", seg, {DARK, DARK, DARK, DARK, DARK, G4, G2, G0}); end
    wr(3'd0, 32'h0);
    step();
    checks++;
    if (seg !== {{7{DARK}}, G0}) begin errors++; $display("FAIL lzs_zero: got %h want %h", seg, {{7{DARK}}, G0}); end
  endtask

  task automatic test_blink();
    int dark;
    int steady_bad;
    bit found;
    wr(3'd0, 32'h1234ABCD);
    wr(3'd2, 32'h01);
    wr(3'd3, 32'h2);
    dark = 0;
    steady_bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (seg[6:0] === DARK) dark++;
      else if (seg[6:0] !== GD) steady_bad++;
      if (seg[55:7] !== {G1, G2, G3, G4, GA, GB, GC}) steady_bad++;
    end
    checks++;
    if (dark != 8) begin errors++; $display("FAIL blink_duty: dark cycles %0d want 8", dark); end
    checks++;
    if (steady_bad != 0) begin errors++; $display("FAIL blink_steady: bad samples %0d want 0", steady_bad); end
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (seg[6:0] === DARK) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL blink_dark_wait: digit0 %h never dark within 12 cycles", seg[6:0]); end
    resetn = 1'b0;
    step();
    checks++;
    if (seg !== '1) begin errors++; $display("FAIL blink_reset: got %h want all ones", seg); end
    resetn = 1'b1;
    step();
    checks++;
    if (seg !== {8{G0}}) begin errors++; $display("FAIL blink_release: got %h want %h", seg, {8{G0}}); end
    dark = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (seg[6:0] !== G0) dark++;
    end
    checks++;
    if (dark != 0) begin errors++; $display("FAIL blink_cleared: digit0 off-glyph %0d times want 0", dark); end
  endtask

  task automatic test_sel_ignore();
    wr(3'd0, 32'h000000F8);
    wr(3'd5, 32'hFFFFFFFF);
    wr(3'd6, 32'hFFFFFFFF);
    wr(3'd7, 32'hFFFFFFFF);
`ifndef SEG_DP_EN
    wr(3'd4, 32'hFFFFFFFF);
`endif
    step();
    checks++;
    if (value_q !== 32'h000000F8) begin errors++; $display("FAIL sel_ignore_value: got %h want 000000f8", value_q); end
    checks++;
    if (seg !== {G0, G0, G0, G0, G0, G0, GF, G8})
      begin errors++; $display("FAIL sel_ignore_seg: got %h want %h", seg, {G0, G0, G0, G0, G0, G0, GF, G8}); end
  endtask

`ifdef SEG_DP_EN
  task automatic test_dp();
    wr(3'd4, 32'h05);
    wr(3'd1, 32'h04);
    step();
    checks++;
    if (dp !== 8'b11111110) begin errors++; $display("FAIL dp_blank: got %b want 11111110", dp); end
    wr(3'd6, 32'hFFFFFFFF);
    step();
    checks++;
    if (dp !== 8'b11111110) begin errors++; $display("FAIL dp_sel6: got %b want 11111110", dp); end
  endtask
`endif

  initial begin
    test_reset();
    test_value();
    test_shift();
    test_lzs();
    test_blink();
    test_sel_ignore();
`ifdef SEG_DP_EN
    test_dp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
